// File: rtl/ahb_burst_arbiter_pkg.sv
// Shared definitions for the AHB burst arbiter: HBURST codes, beat lookup, FSM states.
package ahb_burst_arbiter_pkg;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned BEATS_W = 5;

    localparam logic [2:0] HB_SINGLE = 3'b000;
    localparam logic [2:0] HB_WRAP4  = 3'b010;
    localparam logic [2:0] HB_INCR4  = 3'b011;
    localparam logic [2:0] HB_INCR8  = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Beats per supported HBURST code; 0 marks a code the master cannot run.
    function automatic logic [BEATS_W-1:0] burst_beats(input logic [2:0] code);
        case (code)
            HB_SINGLE:          return BEATS_W'(1);
            HB_WRAP4, HB_INCR4: return BEATS_W'(4);
            HB_INCR8:           return BEATS_W'(8);
            default:            return BEATS_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/ahb_burst_arbiter_if.sv
// Requester/master-side bundle of the burst arbiter.
interface ahb_burst_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 32,
    parameter int unsigned IDW  = 2
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_write;
    logic [NREQ*3-1:0]  req_burst;
    logic               HREADY;
    logic               m_beat_done;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     gnt_id;
    logic               m_start;
    logic [AW-1:0]      m_addr;
    logic               m_write;
    logic [2:0]         m_burst;
    logic [NREQ-1:0]    done;
    logic [NREQ-1:0]    err;

    modport master (
        output req, req_addr, req_write, req_burst, HREADY, m_beat_done,
        input  grant, gnt_id, m_start, m_addr, m_write, m_burst, done, err
    );

    modport slave (
        input  req, req_addr, req_write, req_burst, HREADY, m_beat_done,
        output grant, gnt_id, m_start, m_addr, m_write, m_burst, done, err
    );
endinterface

// File: rtl/ahb_burst_arbiter_rr_picker.sv
// Round-robin picker: first pending requester at or after the pointer, wrapping.
module ahb_burst_arbiter_rr_picker #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] winner_c,
    output logic [IDW-1:0]  idx_c,
    output logic            any_c
);

    logic [IDW-1:0] cand;

    always_comb begin
        winner_c = '0;
        idx_c    = '0;
        any_c    = 1'b0;
        cand     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NREQ);
            if (!any_c && req[cand]) begin
                any_c          = 1'b1;
                winner_c[cand] = 1'b1;
                idx_c          = cand;
            end
        end
    end

endmodule

// File: rtl/ahb_burst_arbiter.sv
// Non-preemptive round-robin arbiter sharing one AHB-Lite burst master among NREQ requesters.
module ahb_burst_arbiter
    import ahb_burst_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 32,
    parameter int unsigned IDW  = 2
) (
    input logic             CLK_MASTER,
    input logic             RESET_MASTER,
    ahb_burst_arbiter_if.slave bus
);

    state_t             state;
    logic [IDW-1:0]     ptr;
    logic [CNT_W-1:0]   beat_cnt;
    logic [CNT_W-1:0]   last_beat;
    logic               bad_cmd;
    logic [NREQ-1:0]    grant_q;
    logic [IDW-1:0]     id_q;
    logic [AW-1:0]      addr_q;
    logic               write_q;
    logic [2:0]         burst_q;
    logic [NREQ-1:0]    done_q;
    logic [NREQ-1:0]    err_q;

    logic [NREQ-1:0]    pick_onehot;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic [AW-1:0]      sel_addr;
    logic [2:0]         sel_burst;
    logic               sel_write;
    logic [BEATS_W-1:0] sel_beats;
    logic [IDW-1:0]     ptr_next_c;

    ahb_burst_arbiter_rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
        .req      (bus.req),
        .ptr      (ptr),
        .winner_c (pick_onehot),
        .idx_c    (pick_idx),
        .any_c    (pick_any)
    );

    // Command fields of the current round-robin winner.
    always_comb begin
        sel_addr  = bus.req_addr[32'(pick_idx)*AW +: AW];
        sel_burst = bus.req_burst[32'(pick_idx)*32'd3 +: 3];
        sel_write = bus.req_write[pick_idx];
        sel_beats = burst_beats(sel_burst);
    end

    assign ptr_next_c = (id_q == IDW'(NREQ-1)) ? '0 : id_q + IDW'(1);

    always_ff @(posedge CLK_MASTER) begin
        if (RESET_MASTER) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            beat_cnt  <= '0;
            last_beat <= '0;
            bad_cmd   <= 1'b0;
            grant_q   <= '0;
            id_q      <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            burst_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_q   <= pick_onehot;
                        id_q      <= pick_idx;
                        addr_q    <= sel_addr;
                        write_q   <= sel_write;
                        burst_q   <= sel_burst;
                        beat_cnt  <= '0;
                        last_beat <= CNT_W'(sel_beats - BEATS_W'(1));
                        bad_cmd   <= (sel_beats == '0);
                        if (sel_beats == '0) err_q <= pick_onehot;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // Rejected commands release the bus without a done pulse.
                    if (bad_cmd) begin
                        grant_q <= '0;
                        id_q    <= '0;
                        ptr     <= ptr_next_c;
                        bad_cmd <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        state   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (bus.HREADY) state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (bus.m_beat_done) begin
                        if (beat_cnt == last_beat) begin
                            done_q <= grant_q;
                            state  <= ST_DONE;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    grant_q  <= '0;
                    id_q     <= '0;
                    ptr      <= ptr_next_c;
                    beat_cnt <= '0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The launch strobe must land in the cycle the slave is ready, so it follows HREADY directly.
    assign bus.m_start = (state == ST_LAUNCH) && bus.HREADY;
    assign bus.grant   = grant_q;
    assign bus.gnt_id  = id_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_write = write_q;
    assign bus.m_burst = burst_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

endmodule
